// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack port,
// and applies next-PC selection when the current instruction retires.
`timescale 1ns/1ps
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC     = 32'h0000_0010,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic [31:0] o_inst,
  output logic        o_inst_vld,
  output logic        o_misalign,
  output logic        o_fetch_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EXEC
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic          vld_q, vld_d;
  logic          req_q, req_d;
  logic          mis_q, mis_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   pc_four;
  logic [31:0]   nxt;
  logic          nxt_bad;

  assign pc_four = pc_q + 32'd4;

  always_comb begin
    nxt = pc_four;
    case (i_pc_sel)
      2'b01:   nxt = i_alu_data;
      2'b10:   nxt = {i_alu_data[31:1], 1'b0};
      default: nxt = pc_four;
    endcase
  end

  // bit0 only matters on the plain ALU target; JALR clears it
  assign nxt_bad = nxt[1] | ((i_pc_sel == 2'b01) & nxt[0]);

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    vld_d   = vld_q;
    req_d   = req_q;
    mis_d   = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
      end
      REQ: begin
        if (i_imem_ack) begin
          inst_d  = i_imem_rdata;
          vld_d   = 1'b1;
          cnt_d   = '0;
          req_d   = 1'b0;
          state_d = EXEC;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) err_d = 1'b1;
        end
      end
      EXEC: begin
        if (!i_stall) begin
          pc_d    = nxt_bad ? TRAP_PC : nxt;
          mis_d   = nxt_bad;
          vld_d   = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_imem_req  = req_q;
  assign o_imem_addr = pc_q;
  assign o_pc        = pc_q;
  assign o_pc_four   = pc_four;
  assign o_inst      = inst_q;
  assign o_inst_vld  = vld_q;
  assign o_misalign  = mis_q;
  assign o_fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected fetch addresses and
// presented instructions are queued, and a negedge monitor pops them.
`timescale 1ns/1ps
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_sel;
  logic [31:0] alu;
  logic        stall;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic [31:0] inst;
  logic        vld;
  logic        mis;
  logic        err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_addr_q[$];
  fetch_t      exp_inst_q[$];
  logic        vld_prev = 1'b0;
  logic [31:0] a_pop;
  fetch_t      f_pop;

  fetch_unit dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_pc_sel    (pc_sel),
    .i_alu_data  (alu),
    .i_stall     (stall),
    .o_imem_req  (req),
    .o_imem_addr (addr),
    .i_imem_ack  (ack),
    .i_imem_rdata(rdata),
    .o_pc        (pc),
    .o_pc_four   (pc_four),
    .o_inst      (inst),
    .o_inst_vld  (vld),
    .o_misalign  (mis),
    .o_fetch_err (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_0013);
  endfunction

  assign rdata = mem(addr);

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    fetch_t f;
    f.pc   = a;
    f.inst = mem(a);
    exp_addr_q.push_back(a);
    exp_inst_q.push_back(f);
  endtask

  // from EXEC with zero-wait memory: retire, check the new request, refetch
  task automatic exec_step(input logic [1:0] sel, input logic [31:0] t,
                           input logic [31:0] nxt, input logic m);
    pc_sel = sel;
    alu    = t;
    stall  = 1'b0;
    expect_fetch(nxt);
    tick();
    check1("step_req", req, 1'b1);
    check("step_addr", addr, nxt);
    check1("step_mis", mis, m);
    check1("step_vld_low", vld, 1'b0);
    tick();
    check1("step_vld", vld, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && req === 1'b1 && ack === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_req: got addr %h expected no request", addr);
      end else begin
        a_pop = exp_addr_q.pop_front();
        check("sb_req_addr", addr, a_pop);
      end
    end
    if (vld === 1'b1 && vld_prev !== 1'b1) begin
      if (exp_inst_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_inst: got inst %h expected none", inst);
      end else begin
        f_pop = exp_inst_q.pop_front();
        check("sb_pc", pc, f_pop.pc);
        check("sb_inst", inst, f_pop.inst);
        check("sb_pc_four", pc_four, f_pop.pc + 32'd4);
      end
    end
    vld_prev = vld;
  end

  initial begin
    rst_n  = 1'b0;
    ack    = 1'b1;
    pc_sel = 2'b00;
    alu    = 32'h0;
    stall  = 1'b0;
    tick();
    tick();
    check1("rst_req", req, 1'b0);
    check1("rst_vld", vld, 1'b0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    check1("rst_mis", mis, 1'b0);
    check1("rst_err", err, 1'b0);

    expect_fetch(32'h0);
    rst_n = 1'b1;
    tick();
    check1("c1_req", req, 1'b1);
    check("c1_addr", addr, 32'h0);
    tick();
    check1("c2_vld", vld, 1'b1);
    check("c2_inst", inst, 32'h0050_0093);
    check("c2_pc_four", pc_four, 32'h4);

    exec_step(2'b00, 32'h0, 32'h4, 1'b0);
    exec_step(2'b01, 32'h100, 32'h100, 1'b0);
    exec_step(2'b10, 32'h205, 32'h204, 1'b0);
    exec_step(2'b11, 32'h0, 32'h208, 1'b0);

    pc_sel = 2'b01;
    alu    = 32'h40;
    stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h208);
      check("stall_inst", inst, mem(32'h208));
      check1("stall_vld", vld, 1'b1);
      check1("stall_req", req, 1'b0);
    end
    exec_step(2'b01, 32'h40, 32'h40, 1'b0);

    exec_step(2'b01, 32'h102, 32'h10, 1'b1);
    check1("mis_pulse_end", mis, 1'b0);
    exec_step(2'b01, 32'h41, 32'h10, 1'b1);
    exec_step(2'b10, 32'h41, 32'h40, 1'b0);

    ack    = 1'b0;
    pc_sel = 2'b00;
    expect_fetch(32'h44);
    tick();
    for (int i = 0; i < 15; i++) tick();
    check1("err_before", err, 1'b0);
    tick();
    check1("err_at_16", err, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check1("err_sticky", err, 1'b1);
    check1("err_req_held", req, 1'b1);
    check("err_addr_held", addr, 32'h44);
    ack = 1'b1;
    tick();
    check1("late_ack_vld", vld, 1'b1);
    check1("late_ack_err", err, 1'b1);

    exec_step(2'b01, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    check("wrap_pc_four", pc_four, 32'h0);
    exec_step(2'b00, 32'h0, 32'h0, 1'b0);

    pc_sel = 2'b00;
    tick();
    check1("pre_rst_req", req, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_inst", inst, 32'h0000_0013);
    check1("mid_rst_vld", vld, 1'b0);
    check("mid_rst_pc", pc, 32'h0);
    check1("mid_rst_req", req, 1'b0);
    check1("mid_rst_err", err, 1'b0);
    expect_fetch(32'h0);
    rst_n = 1'b1;
    tick();
    check1("rerun_req", req, 1'b1);
    tick();
    check1("rerun_vld", vld, 1'b1);

    tick();
    check("sb_addr_drained", 32'(exp_addr_q.size()), 32'd0);
    check("sb_inst_drained", 32'(exp_inst_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
